// File: rtl/gnr_cycle_ctrl.sv
// gnr_cycle_ctrl: sequences a bank of two-trajectory boolean-network nodes through Floyd
// cycle detection. Phase 1 steps tortoise and hare together until they meet on an even
// step count; phase 2 steps the hare alone until it returns to the tortoise, giving the
// attractor period. The result is held on a valid/ready port until accepted.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i, seed_i      run request (sampled in idle only) and seed state
//   s0_vec_i, s1_vec_i   tortoise / hare state vectors read back from the nodes
//   reset_nos_o          node reload strobe (loads init_state_o, arms the tortoise)
//   init_state_o         per-node reload value, held until the next accepted start
//   start_s0_o           tortoise step strobe
//   start_s1_o           hare step strobe
//   busy_o               high whenever the controller is not idle
//   res_valid_o/_ready_i result handshake
//   meet_step_o          tortoise position at which both trajectories met
//   period_o             attractor length
//   timeout_o            run aborted by the step limit
module gnr_cycle_ctrl #(
  parameter int unsigned N_NODES   = 3,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_STEPS = 1024
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [N_NODES-1:0] seed_i,
  input  logic [N_NODES-1:0] s0_vec_i,
  input  logic [N_NODES-1:0] s1_vec_i,
  output logic               reset_nos_o,
  output logic [N_NODES-1:0] init_state_o,
  output logic               start_s0_o,
  output logic               start_s1_o,
  output logic               busy_o,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [CNT_W-1:0]   meet_step_o,
  output logic [CNT_W-1:0]   period_o,
  output logic               timeout_o
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StP1Step,
    StP1Cmp,
    StP2Step,
    StP2Cmp,
    StDone
  } state_e;

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_STEPS);
  localparam logic [CNT_W-1:0] One    = CNT_W'(1);

  state_e             state_q;
  logic [CNT_W-1:0]   k_q;
  logic [CNT_W-1:0]   lam_q;
  logic [N_NODES-1:0] init_q;
  logic [CNT_W-1:0]   meet_q;
  logic [CNT_W-1:0]   period_q;
  logic               timeout_q;
  logic               reset_nos_q;
  logic               start_s0_q;
  logic               start_s1_q;
  logic               busy_q;
  logic               res_valid_q;

  logic vec_eq;
  assign vec_eq = (s0_vec_i == s1_vec_i);

  // Strobes are registered and set on the transition into the state that owns them, so they
  // are high exactly during LOAD / the STEP states and low everywhere else.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      k_q         <= '0;
      lam_q       <= '0;
      init_q      <= '0;
      meet_q      <= '0;
      period_q    <= '0;
      timeout_q   <= 1'b0;
      reset_nos_q <= 1'b0;
      start_s0_q  <= 1'b0;
      start_s1_q  <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      reset_nos_q <= 1'b0;
      start_s0_q  <= 1'b0;
      start_s1_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            init_q      <= seed_i;
            k_q         <= '0;
            lam_q       <= '0;
            timeout_q   <= 1'b0;
            reset_nos_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= StLoad;
          end
        end
        StLoad: begin
          start_s0_q <= 1'b1;
          start_s1_q <= 1'b1;
          state_q    <= StP1Step;
        end
        StP1Step: begin
          k_q     <= k_q + One;
          state_q <= StP1Cmp;
        end
        StP1Cmp: begin
          // Odd k is skipped: the tortoise has moved as often as the hare after one step.
          if (!k_q[0] && vec_eq) begin
            meet_q     <= k_q >> 1;
            start_s1_q <= 1'b1;
            state_q    <= StP2Step;
          end else if (k_q == MaxCnt) begin
            timeout_q   <= 1'b1;
            meet_q      <= '0;
            period_q    <= '0;
            res_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            start_s0_q <= 1'b1;
            start_s1_q <= 1'b1;
            state_q    <= StP1Step;
          end
        end
        StP2Step: begin
          lam_q   <= lam_q + One;
          state_q <= StP2Cmp;
        end
        StP2Cmp: begin
          if (vec_eq) begin
            period_q    <= lam_q;
            res_valid_q <= 1'b1;
            state_q     <= StDone;
          end else if (lam_q == MaxCnt) begin
            timeout_q   <= 1'b1;
            period_q    <= '0;
            res_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            start_s1_q <= 1'b1;
            state_q    <= StP2Step;
          end
        end
        StDone: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign reset_nos_o  = reset_nos_q;
  assign init_state_o = init_q;
  assign start_s0_o   = start_s0_q;
  assign start_s1_o   = start_s1_q;
  assign busy_o       = busy_q;
  assign res_valid_o  = res_valid_q;
  assign meet_step_o  = meet_q;
  assign period_o     = period_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_gnr_cycle_ctrl.sv
module tb_gnr_cycle_ctrl;

  logic clk;
  logic rst_n;

  // DUT A: rotate-left network, default step limit.
  logic        a_start, a_rnos, a_ss0, a_ss1, a_busy, a_rv, a_ready, a_to;
  logic [2:0]  a_seed, a_init, a_s0, a_s1;
  logic [15:0] a_meet, a_per;
  logic        a_arm;

  // DUT B: increment network, step limit 4.
  logic        b_start, b_rnos, b_ss0, b_ss1, b_busy, b_rv, b_ready, b_to;
  logic [2:0]  b_seed, b_init, b_s0, b_s1;
  logic [15:0] b_meet, b_per;
  logic        b_arm;

  int total = 0;
  int bad = 0;
  int viol = 0;
  int rn_cnt = 0;
  logic sel = 1'b0;

  gnr_cycle_ctrl #(.N_NODES(3), .CNT_W(16), .MAX_STEPS(1024)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(a_start), .seed_i(a_seed),
    .s0_vec_i(a_s0), .s1_vec_i(a_s1), .reset_nos_o(a_rnos), .init_state_o(a_init),
    .start_s0_o(a_ss0), .start_s1_o(a_ss1), .busy_o(a_busy), .res_valid_o(a_rv),
    .res_ready_i(a_ready), .meet_step_o(a_meet), .period_o(a_per), .timeout_o(a_to)
  );

  gnr_cycle_ctrl #(.N_NODES(3), .CNT_W(16), .MAX_STEPS(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .seed_i(b_seed),
    .s0_vec_i(b_s0), .s1_vec_i(b_s1), .reset_nos_o(b_rnos), .init_state_o(b_init),
    .start_s0_o(b_ss0), .start_s1_o(b_ss1), .busy_o(b_busy), .res_valid_o(b_rv),
    .res_ready_i(b_ready), .meet_step_o(b_meet), .period_o(b_per), .timeout_o(b_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] rotl(input logic [2:0] s);
    return {s[1:0], s[2]};
  endfunction

  // Node bank models: registered, tortoise moves on odd start_s0 pulses after a reload.
  always @(posedge clk) begin
    if (a_rnos) begin
      a_s0 <= a_init; a_s1 <= a_init; a_arm <= 1'b1;
    end else begin
      if (a_ss0) begin
        if (a_arm) a_s0 <= rotl(a_s0);
        a_arm <= ~a_arm;
      end
      if (a_ss1) a_s1 <= rotl(a_s1);
    end
  end

  always @(posedge clk) begin
    if (b_rnos) begin
      b_s0 <= b_init; b_s1 <= b_init; b_arm <= 1'b1;
    end else begin
      if (b_ss0) begin
        if (b_arm) b_s0 <= b_s0 + 3'd1;
        b_arm <= ~b_arm;
      end
      if (b_ss1) b_s1 <= b_s1 + 3'd1;
    end
  end

  // Selected-DUT views used by the run task.
  logic        rv, busy, rnos, to;
  logic [15:0] meet, per;
  logic [2:0]  init;
  assign rv   = sel ? b_rv   : a_rv;
  assign busy = sel ? b_busy : a_busy;
  assign rnos = sel ? b_rnos : a_rnos;
  assign to   = sel ? b_to   : a_to;
  assign meet = sel ? b_meet : a_meet;
  assign per  = sel ? b_per  : a_per;
  assign init = sel ? b_init : a_init;

  // Strobe protocol monitor: s0 only with s1, never with reset_nos, nothing two cycles running
  // (a strobe in the cycle after a STEP would be a strobe in a CMP state).
  logic a_p0, a_p1, a_pr, b_p0, b_p1, b_pr;
  always @(negedge clk) begin
    if (a_ss0 && !a_ss1) viol++;
    if (b_ss0 && !b_ss1) viol++;
    if ((a_ss0 || a_ss1) && a_rnos) viol++;
    if ((b_ss0 || b_ss1) && b_rnos) viol++;
    if ((a_p0 && a_ss0) || (a_p1 && a_ss1) || (a_pr && a_rnos)) viol++;
    if ((b_p0 && b_ss0) || (b_p1 && b_ss1) || (b_pr && b_rnos)) viol++;
    a_p0 = a_ss0; a_p1 = a_ss1; a_pr = a_rnos;
    b_p0 = b_ss0; b_p1 = b_ss1; b_pr = b_rnos;
    if (rnos) rn_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Starts a run on the selected DUT and waits for the result; optionally acknowledges it.
  task automatic run(input logic which, input logic [2:0] sd, input int exp_lat,
                     input int em, input int ep, input logic et, input logic ack,
                     input string tag);
    int n;
    sel = which;
    @(negedge clk);
    rn_cnt = 0;
    if (which) begin b_seed = sd; b_start = 1'b1; end
    else begin a_seed = sd; a_start = 1'b1; end
    @(posedge clk); #1;
    a_start = 1'b0; b_start = 1'b0;
    chk({tag, "_rnos"}, {31'd0, rnos}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_init"}, {29'd0, init}, {29'd0, sd});
    n = 0;
    while (!rv && n < 2100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_meet"}, {16'd0, meet}, em);
    chk({tag, "_per"}, {16'd0, per}, ep);
    chk({tag, "_to"}, {31'd0, to}, {31'd0, et});
    chk({tag, "_rncnt"}, rn_cnt, 1);
    if (ack) begin
      @(negedge clk);
      a_ready = 1'b1; b_ready = 1'b1;
      @(posedge clk); #1;
      a_ready = 1'b0; b_ready = 1'b0;
      chk({tag, "_ack_rv"}, {31'd0, rv}, 32'd0);
      chk({tag, "_ack_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_hold_init"}, {29'd0, init}, {29'd0, sd});
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    a_start = 1'b0; b_start = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
    a_seed = 3'd0; b_seed = 3'd0;
    a_p0 = 1'b0; a_p1 = 1'b0; a_pr = 1'b0; b_p0 = 1'b0; b_p1 = 1'b0; b_pr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_rv", {31'd0, a_rv}, 32'd0);
    chk("rst_strobes", {29'd0, a_rnos, a_ss0, a_ss1}, 32'd0);
    chk("rst_res", {a_meet, a_per}, 32'd0);
    chk("rst_to_init", {28'd0, a_to, a_init}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Rotate-left, seed 001: attractor of length 3, no tail.
    run(1'b0, 3'b001, 19, 3, 3, 1'b0, 1'b1, "rot001");
    // Fixed point.
    run(1'b0, 3'b000, 7, 1, 1, 1'b0, 1'b1, "rot000");
    // Increment network cannot meet within 4 steps.
    run(1'b1, 3'b000, 9, 0, 0, 1'b1, 1'b1, "inc_to");

    // Backpressure: result held, start ignored while in DONE.
    run(1'b0, 3'b001, 19, 3, 3, 1'b0, 1'b0, "bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a_start = i[0];
      @(posedge clk); #1;
      chk("bp_rv", {31'd0, a_rv}, 32'd1);
      chk("bp_res", {a_meet, a_per}, {16'd3, 16'd3});
      chk("bp_busy", {31'd0, a_busy}, 32'd1);
      chk("bp_rnos", {31'd0, a_rnos}, 32'd0);
    end
    @(negedge clk);
    a_ready = 1'b1; a_start = 1'b1;
    @(posedge clk); #1;
    a_ready = 1'b0; a_start = 1'b0;
    chk("bp_rel_busy", {31'd0, a_busy}, 32'd0);
    chk("bp_rel_rv", {31'd0, a_rv}, 32'd0);
    @(posedge clk); #1;
    chk("bp_no_accept_busy", {31'd0, a_busy}, 32'd0);
    chk("bp_no_accept_rnos", {31'd0, a_rnos}, 32'd0);

    // Reset mid-run, during the first P1_CMP cycle.
    sel = 1'b0;
    @(negedge clk);
    a_seed = 3'b010; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_busy_pre", {31'd0, a_busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_busy", {31'd0, a_busy}, 32'd0);
    chk("mid_rv", {31'd0, a_rv}, 32'd0);
    chk("mid_strobes", {29'd0, a_rnos, a_ss0, a_ss1}, 32'd0);
    chk("mid_res", {a_meet, a_per}, 32'd0);
    chk("mid_to_init", {28'd0, a_to, a_init}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b0, 3'b001, 19, 3, 3, 1'b0, 1'b1, "after_rst");

    repeat (2) @(posedge clk);
    chk("protocol_viol", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
